// File: rtl/ps2_key_event_if.sv
// PS/2 FIFO drain port plus folded key-event outputs. The slave side is the key-event block.
// The master side is whoever owns the ps2_keyboard FIFO and consumes the events.
interface ps2_key_event_if;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_overflow;
  logic       ps2_nextdata_n;

  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_repeat;
  logic       key_down;
  logic [3:0] cnt_ones;
  logic [3:0] cnt_tens;
  logic       err;

  modport master (
    output ps2_data, ps2_ready, ps2_overflow,
    input  ps2_nextdata_n,
    input  key_valid, key_code, key_ext, key_break, key_repeat, key_down,
    input  cnt_ones, cnt_tens, err
  );

  modport slave (
    input  ps2_data, ps2_ready, ps2_overflow,
    output ps2_nextdata_n,
    output key_valid, key_code, key_ext, key_break, key_repeat, key_down,
    output cnt_ones, cnt_tens, err
  );
endinterface

// File: rtl/ps2_key_event.sv
// Folds PS/2 scan bytes (E0/F0 prefixes) into key events with repeat filter and BCD press count.
// key_valid one cycle after the pop strobe; pulls at most one byte per 3 clks, no stall downstream.
module ps2_key_event #(
  parameter int unsigned PREFIX_TIMEOUT = 50000,
  parameter int unsigned COUNT_MAX      = 99
) (
  input logic            clk,
  input logic            clrn,
  ps2_key_event_if.slave bus
);

  localparam bit          TMO_EN   = (PREFIX_TIMEOUT != 0);
  localparam int unsigned TW       = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);
  localparam logic [3:0]  MAX_TENS = 4'((COUNT_MAX / 10) % 10);
  localparam logic [3:0]  MAX_ONES = 4'(COUNT_MAX % 10);
  localparam logic [7:0]  BYTE_EXT = 8'hE0;
  localparam logic [7:0]  BYTE_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  state_t     state_q;
  logic       nextdata_n_q;
  logic [7:0] byte_q;

  // GAP exists because ps2_ready may still reflect the byte just popped.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      nextdata_n_q <= 1'b1;
      byte_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ps2_ready) begin
            byte_q       <= bus.ps2_data;
            nextdata_n_q <= 1'b0;
            state_q      <= POP;
          end
        end
        POP: begin
          nextdata_n_q <= 1'b1;
          state_q      <= GAP;
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          nextdata_n_q <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          valid_q, valid_d;
  logic [7:0]    code_q, code_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic          rep_q, rep_d;
  logic          down_q, down_d;
  logic [7:0]    held_code_q, held_code_d;
  logic          held_ext_q, held_ext_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;

  logic decode;
  logic is_ext;
  logic is_brk;
  logic pend;
  logic tmo_hit;
  logic held_match;

  assign decode     = (state_q == POP);
  assign is_ext     = (byte_q == BYTE_EXT);
  assign is_brk     = (byte_q == BYTE_BRK);
  assign pend       = ext_pend_q | brk_pend_q;
  assign tmo_hit    = TMO_EN && pend && (tmo_q == TMO_LAST);
  assign held_match = down_q && (held_code_q == byte_q) && (held_ext_q == ext_pend_q);

  always_comb begin
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    valid_d     = 1'b0;
    code_d      = code_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    rep_d       = rep_q;
    down_d      = down_q;
    held_code_d = held_code_q;
    held_ext_d  = held_ext_q;
    ones_d      = ones_q;
    tens_d      = tens_q;

    if (TMO_EN && pend) begin
      tmo_d = tmo_q + 1'b1;
    end

    if (decode && is_ext) begin
      ext_pend_d = 1'b1;
      tmo_d      = '0;
    end else if (decode && is_brk) begin
      brk_pend_d = 1'b1;
      tmo_d      = '0;
    end else if (decode) begin
      valid_d    = 1'b1;
      code_d     = byte_q;
      ext_d      = ext_pend_q;
      brk_d      = brk_pend_q;
      rep_d      = ~brk_pend_q & held_match;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
      tmo_d      = '0;
      if (brk_pend_q) begin
        if (held_match) begin
          down_d = 1'b0;
        end
      end else if (!held_match) begin
        // Fresh press: a different key simply takes over the single held slot.
        held_code_d = byte_q;
        held_ext_d  = ext_pend_q;
        down_d      = 1'b1;
        if (ones_q == MAX_ONES && tens_q == MAX_TENS) begin
          ones_d = 4'd0;
          tens_d = 4'd0;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end
    end else if (tmo_hit) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
      tmo_d      = '0;
      err_d      = 1'b1;
    end

    // Overflow clears prefixes after the event above has already latched them.
    if (bus.ps2_overflow) begin
      err_d      = 1'b1;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
      tmo_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      code_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      rep_q       <= 1'b0;
      down_q      <= 1'b0;
      held_code_q <= '0;
      held_ext_q  <= 1'b0;
      ones_q      <= '0;
      tens_q      <= '0;
    end else begin
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      rep_q       <= rep_d;
      down_q      <= down_d;
      held_code_q <= held_code_d;
      held_ext_q  <= held_ext_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
    end
  end

  assign bus.ps2_nextdata_n = nextdata_n_q;
  assign bus.key_valid      = valid_q;
  assign bus.key_code       = code_q;
  assign bus.key_ext        = ext_q;
  assign bus.key_break      = brk_q;
  assign bus.key_repeat     = rep_q;
  assign bus.key_down       = down_q;
  assign bus.cnt_ones       = ones_q;
  assign bus.cnt_tens       = tens_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event: a byte FIFO model feeds the DUT, events are logged at negedge.
module tb_ps2_key_event;
  logic clk  = 1'b0;
  logic clrn = 1'b0;
  logic ovf  = 1'b0;
  always #5 clk = ~clk;

  ps2_key_event_if bus ();

  ps2_key_event #(.PREFIX_TIMEOUT(8), .COUNT_MAX(99)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  logic [7:0]  mem [256];
  int          wr = 0;
  int          rd = 0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [10:0] evq [$];
  int          popq [$];

  assign bus.ps2_ready    = (wr != rd);
  assign bus.ps2_data     = mem[rd[7:0]];
  assign bus.ps2_overflow = ovf;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ps2_nextdata_n == 1'b0 && wr != rd) rd <= rd + 1;
  end

  always @(negedge clk) begin
    if (bus.key_valid !== 1'b0)
      evq.push_back({bus.key_ext, bus.key_break, bus.key_repeat, bus.key_code});
    if (bus.ps2_nextdata_n !== 1'b1) popq.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    mem[wr[7:0]] = b;
    wr = wr + 1;
  endtask

  task automatic drain();
    int n = 0;
    while (wr != rd && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", wr - rd, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_ev(input string tag, input logic [7:0] code,
                           input logic ext, input logic brk, input logic rep);
    logic [10:0] e;
    if (evq.size() == 0) e = 11'h7FF;
    else e = evq.pop_front();
    chk(tag, 32'(e), 32'({ext, brk, rep, code}));
  endtask

  task automatic clear_ev();
    logic [10:0] e;
    while (evq.size() > 0) e = evq.pop_front();
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    clear_ev();
  endtask

  function automatic logic [31:0] cnt();
    return 32'({bus.cnt_tens, bus.cnt_ones});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] k;
    int n;

    repeat (3) @(negedge clk);
    chk("rst nextdata_n", 32'(bus.ps2_nextdata_n), 1);
    chk("rst key_valid", 32'(bus.key_valid), 0);
    chk("rst key_down", 32'(bus.key_down), 0);
    chk("rst cnt", cnt(), 0);
    chk("rst err", 32'(bus.err), 0);
    chk("rst key_code", 32'(bus.key_code), 0);
    clrn = 1'b1;
    @(negedge clk);

    // 1: press then release
    send(8'h1C); drain();
    expect_ev("t1 press", 8'h1C, 1'b0, 1'b0, 1'b0);
    chk("t1 cnt", cnt(), 32'h01);
    chk("t1 down", 32'(bus.key_down), 1);
    send(8'hF0); send(8'h1C); drain();
    expect_ev("t1 break", 8'h1C, 1'b0, 1'b1, 1'b0);
    chk("t1 up", 32'(bus.key_down), 0);
    chk("t1 no extra", evq.size(), 0);

    // 2: typematic repeats
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); drain();
    expect_ev("t2 p1", 8'h1C, 1'b0, 1'b0, 1'b0);
    expect_ev("t2 p2", 8'h1C, 1'b0, 1'b0, 1'b1);
    expect_ev("t2 p3", 8'h1C, 1'b0, 1'b0, 1'b1);
    chk("t2 cnt", cnt(), 32'h01);
    chk("t2 down", 32'(bus.key_down), 1);
    send(8'hF0); send(8'h1C); drain();
    expect_ev("t2 break", 8'h1C, 1'b0, 1'b1, 1'b0);
    chk("t2 up", 32'(bus.key_down), 0);

    // 3: extended keys, both prefix orders, break of a non-held key
    send(8'hE0); send(8'h75); drain();
    expect_ev("t3 ext press", 8'h75, 1'b1, 1'b0, 1'b0);
    chk("t3 cnt a", cnt(), 32'h02);
    send(8'hE0); send(8'hF0); send(8'h75); drain();
    expect_ev("t3 E0F0 break", 8'h75, 1'b1, 1'b1, 1'b0);
    chk("t3 up a", 32'(bus.key_down), 0);
    send(8'hE0); send(8'h75); send(8'hF0); send(8'hE0); send(8'h75); drain();
    expect_ev("t3 ext press2", 8'h75, 1'b1, 1'b0, 1'b0);
    expect_ev("t3 F0E0 break", 8'h75, 1'b1, 1'b1, 1'b0);
    chk("t3 cnt b", cnt(), 32'h03);
    send(8'h1C); send(8'hF0); send(8'h32); send(8'h1C); drain();
    expect_ev("t3 press 1C", 8'h1C, 1'b0, 1'b0, 1'b0);
    expect_ev("t3 other break", 8'h32, 1'b0, 1'b1, 1'b0);
    expect_ev("t3 still held", 8'h1C, 1'b0, 1'b0, 1'b1);
    chk("t3 down", 32'(bus.key_down), 1);
    chk("t3 cnt c", cnt(), 32'h04);
    send(8'hE0); send(8'h1C); drain();
    expect_ev("t3 ext differs", 8'h1C, 1'b1, 1'b0, 1'b0);
    chk("t3 cnt d", cnt(), 32'h05);

    // 4: BCD wrap over 100 fresh presses
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      k = i[0] ? 8'h1C : 8'h32;
      send(k); drain();
      if (i == 9)   chk("t4 cnt09", cnt(), 32'h09);
      if (i == 10)  chk("t4 cnt10", cnt(), 32'h10);
      if (i == 99)  chk("t4 cnt99", cnt(), 32'h99);
      if (i == 100) begin
        chk("t4 cnt00", cnt(), 32'h00);
        expect_ev("t4 last press", k, 1'b0, 1'b0, 1'b0);
      end
      send(8'hF0); send(k); drain();
      clear_ev();
    end

    // 5: prefix timeout, exact boundary
    do_reset();
    send(8'hF0); drain();
    repeat (4) @(negedge clk);
    chk("t5 err before", 32'(bus.err), 0);
    @(negedge clk);
    chk("t5 err at timeout", 32'(bus.err), 1);
    chk("t5 no event", evq.size(), 0);
    send(8'h1C); drain();
    expect_ev("t5 press after", 8'h1C, 1'b0, 1'b0, 1'b0);
    chk("t5 cnt", cnt(), 32'h01);
    chk("t5 err sticky", 32'(bus.err), 1);

    // overflow sets err and drops pending prefix
    do_reset();
    send(8'hE0); drain();
    ovf = 1'b1;
    @(negedge clk);
    ovf = 1'b0;
    chk("ovf err", 32'(bus.err), 1);
    send(8'h75); drain();
    expect_ev("ovf prefix dropped", 8'h75, 1'b0, 1'b0, 1'b0);

    // 6: pop spacing and mid-POP reset
    do_reset();
    while (popq.size() > 0) n = popq.pop_front();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); drain();
    chk("t6 pops", popq.size(), 4);
    for (int i = 1; i < 4; i++)
      if (popq.size() > i) chk("t6 spacing", popq[i] - popq[i-1], 3);
    clear_ev();
    send(8'h1C);
    n = 0;
    while (bus.ps2_nextdata_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6 in POP", 32'(bus.ps2_nextdata_n), 0);
    clrn = 1'b0;
    #1;
    chk("t6 async nextdata_n", 32'(bus.ps2_nextdata_n), 1);
    @(negedge clk);
    chk("t6 no partial", evq.size(), 0);
    clrn = 1'b1;
    drain();
    expect_ev("t6 refetch", 8'h1C, 1'b0, 1'b0, 1'b0);
    chk("t6 cnt", cnt(), 32'h01);
    chk("t6 no extra", evq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
